digit_scan: RTL and testbench
=============================

DIGIT_SCAN -- requirements
Module: digit_scan

Interface
REQ-001 SHALL provide parameter DWELL, default 16, the number of clk cycles each digit strobe stays active (legal range 2..255).
REQ-002 SHALL provide port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL provide port eoc  input  1  end-of-conversion pulse, one cycle wide; qualifies the result inputs.
REQ-005 SHALL provide port bcd_in  input  12  three full BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 SHALL provide port msd  input  1  half-digit (thousands) value, 0 or 1.
REQ-007 SHALL provide port pol  input  1  sign; 1 = positive.
REQ-008 SHALL provide port ovr  input  1  over-range flag.
REQ-009 SHALL provide port ds  output  4  one-hot digit strobes; ds[3] = MSD slot, ds[0] = units slot.
REQ-010 SHALL provide port q  output  4  BCD or status code for the active slot.
REQ-011 SHALL provide port du  output  1  display-update pulse, one cycle wide, when new data enters the frame.

Function
REQ-012 States: IDLE (no result yet) and SCAN; rst forces IDLE.
REQ-013 IDLE -> SCAN on the first eoc; SCAN is never left except by rst.
REQ-014 On eoc, bcd_in/msd/pol/ovr SHALL be captured into a shadow register in the same edge.
REQ-015 Shadow-to-display transfer SHALL occur only at a frame start (entry to the ds[3] slot), so no frame mixes two results.
REQ-016 du SHALL pulse high on the cycle the transfer takes effect, and SHALL stay low if no eoc arrived since the previous transfer.
REQ-017 In SCAN, ds SHALL step 1000 -> 0100 -> 0010 -> 0001 -> 1000, each slot lasting exactly DWELL cycles, for a frame period of 4*DWELL.
REQ-018 The dwell counter SHALL wrap from DWELL-1 to 0 and advance ds in the same edge.
REQ-019 MSD slot q: q[3] = msd, q[2] = pol, q[1] = 0, q[0] = ovr.
REQ-020 Other slots: q = the corresponding displayed BCD digit.
REQ-021 eoc arriving on the same edge as the frame start SHALL be captured and used in that frame.
REQ-022 The first eoc in IDLE SHALL enter SCAN with ds = 1000 on the next cycle, with the new data displayed and du = 1.
REQ-023 Two eoc pulses within one frame: the last one wins.
REQ-024 BCD digits > 9 SHALL pass through unmodified; no range checking.

Reset
REQ-025 On rst: ds = 0000, q = 0000, du = 0, dwell counter = 0, shadow and display registers = 0, pending flag = 0, state = IDLE.
REQ-026 rst asserted mid-frame SHALL abort the scan on the next edge; any pending result is lost.

Configuration
REQ-027 Macro LEADING_ZERO_BLANK_EN.
REQ-028 With the macro defined: a hundreds digit of 0 when msd = 0 SHALL output q = 4'hF (blank); the tens digit SHALL also blank when msd = 0, hundreds = 0 and tens = 0. The units digit is never blanked.
REQ-029 With the macro undefined: no blanking; q always equals the stored digit.

Structure
REQ-030 The shared package SHALL hold the state enum (IDLE, SCAN), the strobe constants DS_MSD/DS_HUN/DS_TEN/DS_UNI, and the BLANK_CODE = 4'hF constant.
REQ-031 The dwell counter SHALL be one sub-module, dwell_cnt, producing a terminal-count pulse; all other logic stays in digit_scan.

Verification
REQ-032 rst held 3 cycles, then released with no eoc for 100 cycles -> ds = 0000, q = 0000, du = 0 throughout.
REQ-033 DWELL = 4; eoc with bcd_in = 12'h753, msd = 1, pol = 1, ovr = 0 -> du pulse; ds = 1000 with q = 1100 for 4 cycles; then q = 7, 5, 3 on ds = 0100, 0010, 0001 respectively; the pattern repeats every 16 cycles.
REQ-034 Second eoc (bcd_in = 12'h111) during the ds = 0010 slot -> the current frame finishes with 753; the next frame shows 111 with du = 1 at its first cycle.
REQ-035 eoc coincident with the frame-start edge -> that frame displays the new data and du = 1 on that cycle.
REQ-036 LEADING_ZERO_BLANK_EN defined; bcd_in = 12'h005, msd = 0 -> hundreds and tens slots output q = F, units slot outputs q = 5; with the macro undefined -> 0, 0, 5.
REQ-037 rst asserted during the ds = 0100 slot -> ds = 0000 next cycle; after release, ds stays 0000 until a fresh eoc.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Shared definitions for the digit_scan multiplexed display driver.
package digit_scan_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   // One-hot digit strobes, MSD slot first in the frame
   localparam logic [3:0] DS_OFF = 4'b0000;
   localparam logic [3:0] DS_MSD = 4'b1000;
   localparam logic [3:0] DS_HUN = 4'b0100;
   localparam logic [3:0] DS_TEN = 4'b0010;
   localparam logic [3:0] DS_UNI = 4'b0001;

   // Code driven on q for a suppressed leading zero
   localparam logic [3:0] BLANK_CODE = 4'hF;

   // Next strobe in the frame; units slot wraps back to the MSD slot
   function automatic logic [3:0] ds_next(input logic [3:0] cur);
      return {cur[0], cur[3:1]};
   endfunction

endpackage

// File: rtl/digit_scan_dwell_cnt.sv
// Dwell counter: counts clk cycles within one digit slot and flags the
// last cycle of the slot. Held at zero while disabled.
module dwell_cnt #(
   parameter int DWELL = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   output logic o_tc
);

   logic [7:0] r_cnt;

   assign o_tc = i_en && (r_cnt == 8'(DWELL - 1));

   // Count up while enabled, wrap to zero on terminal count
   always_ff @(posedge clk) begin
      if (rst || !i_en)
         r_cnt <= 8'd0;
      else if (o_tc)
         r_cnt <= 8'd0;
      else
         r_cnt <= r_cnt + 8'd1;
   end

endmodule

// File: rtl/digit_scan.sv
// digit_scan: 3.5-digit multiplexed display scanner.
// A conversion result is latched into a shadow register on eoc and moved
// to the display register only at a frame start, so a frame never mixes
// two results. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros
// in the hundreds and tens slots.
module digit_scan
   import digit_scan_pkg::*;
#(
   parameter int DWELL = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        eoc,
   input  logic [11:0] bcd_in,
   input  logic        msd,
   input  logic        pol,
   input  logic        ovr,
   output logic [3:0]  ds,
   output logic [3:0]  q,
   output logic        du
);

   // Packed result layout: [14] msd, [13] pol, [12] ovr, [11:0] BCD digits
   state_e      r_state;
   logic [3:0]  r_ds;
   logic        r_du;
   logic        r_pend;
   logic [14:0] r_shadow;
   logic [14:0] r_disp;

   logic [14:0] w_in;
   logic        w_tc;
   logic        w_frame_start;
   logic        w_blank_h;
   logic        w_blank_t;
   logic [3:0]  w_q;

   assign w_in          = {msd, pol, ovr, bcd_in};
   assign w_frame_start = w_tc && (r_ds == DS_UNI);

   dwell_cnt #(.DWELL(DWELL)) u_dwell (
      .clk  (clk),
      .rst  (rst),
      .i_en (r_state == SCAN),
      .o_tc (w_tc)
   );

   // Scan FSM, strobe rotation and shadow/display transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_ds     <= DS_OFF;
         r_du     <= 1'b0;
         r_pend   <= 1'b0;
         r_shadow <= '0;
         r_disp   <= '0;
      end else begin
         r_du <= 1'b0;
         if (eoc)
            r_shadow <= w_in;
         case (r_state)
            IDLE: begin
               // First result starts scanning immediately with a fresh frame
               if (eoc) begin
                  r_state <= SCAN;
                  r_ds    <= DS_MSD;
                  r_disp  <= w_in;
                  r_du    <= 1'b1;
                  r_pend  <= 1'b0;
               end
            end
            SCAN: begin
               if (w_tc)
                  r_ds <= ds_next(r_ds);
               if (w_frame_start) begin
                  // A result arriving on the frame-start edge is used directly
                  if (eoc) begin
                     r_disp <= w_in;
                     r_du   <= 1'b1;
                     r_pend <= 1'b0;
                  end else if (r_pend) begin
                     r_disp <= r_shadow;
                     r_du   <= 1'b1;
                     r_pend <= 1'b0;
                  end
               end else if (eoc) begin
                  r_pend <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Select the code for the active slot, with optional zero blanking
   always_comb begin
      w_q       = 4'h0;
      w_blank_h = 1'b0;
      w_blank_t = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      w_blank_h = !r_disp[14] && (r_disp[11:8] == 4'h0);
      w_blank_t = w_blank_h && (r_disp[7:4] == 4'h0);
`endif
      case (r_ds)
         DS_MSD: w_q = {r_disp[14], r_disp[13], 1'b0, r_disp[12]};
         DS_HUN: w_q = w_blank_h ? BLANK_CODE : r_disp[11:8];
         DS_TEN: w_q = w_blank_t ? BLANK_CODE : r_disp[7:4];
         DS_UNI: w_q = r_disp[3:0];
         default: w_q = 4'h0;
      endcase
   end

   assign ds = r_ds;
   assign q  = w_q;
   assign du = r_du;

endmodule

// File: tb/tb_digit_scan.sv
// Scoreboard bench for digit_scan. The reference model tracks the scan as
// a cycle position within the frame (slot = position / DWELL) plus the
// latest displayed and pending results.
module tb_digit_scan;

   localparam int DWELL = 4;
   localparam int FRAME = 4 * DWELL;

   logic        clk = 1'b0;
   logic        rst, eoc, msd, pol, ovr;
   logic [11:0] bcd_in;
   logic [3:0]  ds, q;
   logic        du;

   always #5 clk = ~clk;

   digit_scan #(.DWELL(DWELL)) dut (
      .clk    (clk),
      .rst    (rst),
      .eoc    (eoc),
      .bcd_in (bcd_in),
      .msd    (msd),
      .pol    (pol),
      .ovr    (ovr),
      .ds     (ds),
      .q      (q),
      .du     (du)
   );

   typedef struct {
      logic [3:0] ds;
      logic [3:0] q;
      logic       du;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_tmo = 0;
   bit   done = 1'b0;

   // Reference model state
   bit          m_scan = 1'b0;
   int          m_t = 0;
   logic [14:0] m_disp = '0;
   logic [14:0] m_shadow = '0;
   bit          m_pend = 1'b0;
   bit          m_du = 1'b0;

   function automatic logic [3:0] slot_q(input int slot, input logic [14:0] d);
      bit bh, bt;
      bh = 1'b0;
      bt = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      bh = (d[14] == 1'b0) && (d[11:8] == 4'd0);
      bt = bh && (d[7:4] == 4'd0);
`endif
      case (slot)
         0: return {d[14], d[13], 1'b0, d[12]};
         1: return bh ? 4'hF : d[11:8];
         2: return bt ? 4'hF : d[7:4];
         default: return d[3:0];
      endcase
   endfunction

   // Advance the model by one clock edge using the currently driven inputs
   task automatic model_step();
      logic [14:0] din;
      logic [3:0]  top;
      exp_t        e;
      din = {msd, pol, ovr, bcd_in};
      top = 4'b1000;
      if (rst) begin
         m_scan = 1'b0; m_t = 0; m_disp = '0; m_shadow = '0;
         m_pend = 1'b0; m_du = 1'b0;
      end else begin
         m_du = 1'b0;
         if (!m_scan) begin
            if (eoc) begin
               m_scan = 1'b1; m_t = 0; m_disp = din; m_pend = 1'b0; m_du = 1'b1;
            end
         end else begin
            m_t = (m_t + 1) % FRAME;
            if (m_t == 0) begin
               if (eoc) begin
                  m_disp = din; m_du = 1'b1; m_pend = 1'b0;
               end else if (m_pend) begin
                  m_disp = m_shadow; m_du = 1'b1; m_pend = 1'b0;
               end
            end else if (eoc) begin
               m_pend = 1'b1;
            end
         end
         if (eoc) m_shadow = din;
      end
      e.du = m_du;
      if (m_scan) begin
         e.ds = top >> (m_t / DWELL);
         e.q  = slot_q(m_t / DWELL, m_disp);
      end else begin
         e.ds = 4'b0000;
         e.q  = 4'b0000;
      end
      sb.push_back(e);
   endtask

   task automatic tick(input logic r, input logic e, input logic [11:0] b,
                       input logic m, input logic p, input logic o);
      @(negedge clk);
      rst = r; eoc = e; bcd_in = b; msd = m; pol = p; ovr = o;
      model_step();
   endtask

   // Cycles without eoc; data lines carry junk that must be ignored
   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         tick(1'b0, 1'b0, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   // Idle until the model's current frame position lies in [lo, hi]
   task automatic wait_t(input int lo, input int hi);
      int k;
      k = 0;
      while (!(m_scan && m_t >= lo && m_t <= hi) && k < 4 * FRAME) begin
         idle(1);
         k++;
      end
      if (k >= 4 * FRAME) n_tmo++;
   endtask

   task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Monitor: one expected response per cycle of DUT output
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("ds", ds, mon_e.ds);
            chk("q",  q,  mon_e.q);
            chk("du", {3'b000, du}, {3'b000, mon_e.du});
         end
         if (done) begin
            n_chk++;
            if (n_tmo != 0 || sb.size() != 0) begin
               n_fail++;
               $display("FAIL wait_bound: timeouts %0d leftover %0d expected 0 0", n_tmo, sb.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
            $finish;
         end
      end
   end

   // Stimulus
   initial begin
      logic [11:0] b;
      int          sel;
      rst = 1'b1; eoc = 1'b0; bcd_in = '0; msd = 1'b0; pol = 1'b0; ovr = 1'b0;
      repeat (3) tick(1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
      idle(100);
      // Basic frame 753 with status slot 1100
      tick(1'b0, 1'b1, 12'h753, 1'b1, 1'b1, 1'b0);
      idle(2 * FRAME);
      // New result mid-frame waits for next frame start
      wait_t(2 * DWELL, 3 * DWELL - 1);
      tick(1'b0, 1'b1, 12'h111, 1'b0, 1'b1, 1'b0);
      idle(2 * FRAME);
      // Result coincident with the frame-start edge
      wait_t(FRAME - 1, FRAME - 1);
      tick(1'b0, 1'b1, 12'h246, 1'b1, 1'b0, 1'b1);
      idle(FRAME);
      // Two results in one frame: last wins
      wait_t(DWELL, DWELL);
      tick(1'b0, 1'b1, 12'h321, 1'b0, 1'b0, 1'b0);
      idle(1);
      tick(1'b0, 1'b1, 12'h9AF, 1'b1, 1'b1, 1'b1);
      idle(2 * FRAME);
      // Reset in the hundreds slot, then stay blank until a fresh eoc
      wait_t(DWELL, 2 * DWELL - 1);
      tick(1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
      idle(20);
      // Leading zeros
      tick(1'b0, 1'b1, 12'h005, 1'b0, 1'b1, 1'b0);
      idle(2 * FRAME);
      tick(1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
      wait_t(FRAME - 1, FRAME - 1);
      tick(1'b0, 1'b1, 12'h040, 1'b0, 1'b0, 1'b0);
      idle(2 * FRAME);
      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         sel = int'($urandom_range(0, 2));
         b = (sel == 0) ? 12'($urandom_range(0, 15)) :
             (sel == 1) ? 12'($urandom_range(0, 255)) : 12'($urandom_range(0, 4095));
         tick(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 9) == 0), b,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      repeat (3) @(negedge clk);
      done = 1'b1;
   end

endmodule
